// File: rtl/lif_layer_param.sv
// lif_layer_param: N_NEURONS leaky integrate-and-fire hidden neurons feeding one
// weighted output neuron. One time step per `step` pulse; hidden spikes appear
// one cycle after the step, the output spike one cycle later, and the saturating
// spike counter one cycle after that.
// Optional build macro: LIF_REFRACTORY_EN adds a per-hidden-neuron refractory
// counter of REFRAC_STEPS steps after each hidden spike.
module lif_layer_param #(
   parameter  int N_NEURONS    = 4,
   parameter  int W            = 8,
   parameter  int IN_W         = 5,
   parameter  int LEAK_SHIFT   = 3,
   parameter  int OUT_WEIGHT   = 16,
   parameter  int OUT_THRESH   = 32,
   parameter  int REFRAC_STEPS = 2,
   localparam int SEL_W        = $clog2(N_NEURONS + 1)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      step,
   input  logic [N_NEURONS*IN_W-1:0] current,
   input  logic [W-1:0]              threshold,
   input  logic                      count_clr,
   input  logic [SEL_W-1:0]          mon_sel,
   output logic [N_NEURONS-1:0]      spike,
   output logic                      spike_out,
   output logic [7:0]                spike_count,
   output logic [W-1:0]              v_mon
);

   // Output-neuron arithmetic is done at 32 bits so the weighted spike sum cannot wrap.
   localparam logic [31:0] OW   = OUT_WEIGHT;
   localparam logic [31:0] OTH  = OUT_THRESH;
   localparam logic [31:0] VMAX = (32'd1 << W) - 32'd1;

   // Reject parameter sets outside the supported range at elaboration.
   if (N_NEURONS < 1 || N_NEURONS > 8 || IN_W > W || REFRAC_STEPS < 0) begin : g_bad_param
      $error("lif_layer_param: unsupported parameter set");
   end

   logic [W-1:0] v_all [N_NEURONS];

   // ---------------------------------------------------------------- hidden neurons
   for (genvar i = 0; i < N_NEURONS; i++) begin : g_hid
      logic [W-1:0] v_q, v_d;
      logic         spike_q, spike_d;
      logic [W:0]   sum;
      logic [W-1:0] sum_sat;

      // Leak-and-integrate at W+1 bits, then clamp to the W-bit range.
      always_comb begin
         sum     = {1'b0, v_q} - {1'b0, (v_q >> LEAK_SHIFT)}
                 + (W+1)'(current[i*IN_W +: IN_W]);
         sum_sat = sum[W] ? {W{1'b1}} : sum[W-1:0];
      end

`ifdef LIF_REFRACTORY_EN
      localparam int RC_W = (REFRAC_STEPS > 0) ? $clog2(REFRAC_STEPS + 1) : 1;
      logic [RC_W-1:0] rc_q, rc_d;

      // Step update; a live refractory count pins v to 0 and suppresses firing.
      always_comb begin
         v_d     = v_q;
         spike_d = 1'b0;
         rc_d    = rc_q;
         if (step) begin
            if (rc_q != '0) begin
               rc_d = rc_q - 1'b1;
               v_d  = '0;
            end else if (sum_sat >= threshold) begin
               v_d     = '0;
               spike_d = 1'b1;
               rc_d    = RC_W'(REFRAC_STEPS);
            end else begin
               v_d = sum_sat;
            end
         end
      end

      // Refractory counter state.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) rc_q <= '0;
         else        rc_q <= rc_d;
      end
`else
      // Step update: fire and reset on threshold, otherwise keep the integrated value.
      always_comb begin
         v_d     = v_q;
         spike_d = 1'b0;
         if (step) begin
            if (sum_sat >= threshold) begin
               v_d     = '0;
               spike_d = 1'b1;
            end else begin
               v_d = sum_sat;
            end
         end
      end
`endif

      // Membrane and one-cycle spike registers.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            v_q     <= '0;
            spike_q <= 1'b0;
         end else begin
            v_q     <= v_d;
            spike_q <= spike_d;
         end
      end

      assign v_all[i] = v_q;
      assign spike[i] = spike_q;
   end

   // ---------------------------------------------------------------- output neuron
   logic         step_d_q;
   logic [W-1:0] vo_q, vo_d;
   logic         so_q, so_d;
   logic [31:0]  pop, osum;
   logic [W-1:0] osat;

   // Weighted popcount of the registered hidden spikes, leaked and clamped.
   always_comb begin
      pop = '0;
      for (int k = 0; k < N_NEURONS; k++) pop = pop + 32'(spike[k]);
      osum = 32'(vo_q) - 32'(vo_q >> LEAK_SHIFT) + OW * pop;
      osat = (osum > VMAX) ? {W{1'b1}} : osum[W-1:0];
   end

   // Output neuron fires on the delayed step, same reset rule as hidden neurons.
   always_comb begin
      vo_d = vo_q;
      so_d = 1'b0;
      if (step_d_q) begin
         if (32'(osat) >= OTH) begin
            vo_d = '0;
            so_d = 1'b1;
         end else begin
            vo_d = osat;
         end
      end
   end

   // Output neuron state and the step delay that keys it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         step_d_q <= 1'b0;
         vo_q     <= '0;
         so_q     <= 1'b0;
      end else begin
         step_d_q <= step;
         vo_q     <= vo_d;
         so_q     <= so_d;
      end
   end

   assign spike_out = so_q;

   // ---------------------------------------------------------------- spike counter
   logic [7:0] cnt_q, cnt_d;

   // Clear beats a coincident pulse; the count sticks at 255.
   always_comb begin
      cnt_d = cnt_q;
      if (count_clr)                    cnt_d = '0;
      else if (so_q && cnt_q != 8'hFF)  cnt_d = cnt_q + 8'd1;
   end

   // Counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign spike_count = cnt_q;

   // ---------------------------------------------------------------- monitor mux
   // Combinational view of one membrane; unused select codes read as 0.
   always_comb begin
      v_mon = '0;
      for (int k = 0; k < N_NEURONS; k++)
         if (mon_sel == SEL_W'(k)) v_mon = v_all[k];
      if (mon_sel == SEL_W'(N_NEURONS)) v_mon = vo_q;
   end

endmodule

// File: tb/tb_lif_layer_param.sv
// Scoreboard bench for lif_layer_param: a driver applies stimulus, advances an
// integer reference model of the layer and queues the expected post-edge outputs;
// a monitor pops one entry per cycle and compares against the pins.
module tb_lif_layer_param;
   localparam int N = 4, W = 8, IN_W = 5, LS = 3, OWT = 16, OTH = 32, RS = 2;
`ifdef LIF_REFRACTORY_EN
   localparam bit REF_EN = 1'b1;
`else
   localparam bit REF_EN = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            step = 1'b0;
   logic [N*IN_W-1:0] current = '0;
   logic [W-1:0]    threshold = '0;
   logic            count_clr = 1'b0;
   logic [2:0]      mon_sel = '0;
   logic [N-1:0]    spike;
   logic            spike_out;
   logic [7:0]      spike_count;
   logic [W-1:0]    v_mon;

   lif_layer_param #(.N_NEURONS(N), .W(W), .IN_W(IN_W), .LEAK_SHIFT(LS),
                     .OUT_WEIGHT(OWT), .OUT_THRESH(OTH), .REFRAC_STEPS(RS)) dut (
      .clk(clk), .rst_n(rst_n), .step(step), .current(current), .threshold(threshold),
      .count_clr(count_clr), .mon_sel(mon_sel), .spike(spike), .spike_out(spike_out),
      .spike_count(spike_count), .v_mon(v_mon));

   always #5 clk = ~clk;

   typedef struct {
      logic [N-1:0] spk;
      logic         so;
      logic [7:0]   cnt;
      logic [W-1:0] vmon;
   } exp_t;
   exp_t q[$];

   int total = 0, bad = 0;

   // reference state
   int mv[N], mrc[N], mspk[N];
   int mvo, mso, mcnt, mstd;

   task automatic check(input string name, input int act, input int expv);
      total++;
      if (act != expv) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
      end
   endtask

   function automatic int sat(input int x);
      return (x > 255) ? 255 : x;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin mv[i] = 0; mrc[i] = 0; mspk[i] = 0; end
      mvo = 0; mso = 0; mcnt = 0; mstd = 0;
   endtask

   // One rising edge of the layer, described by its step rules.
   task automatic model_edge(input bit st, input logic [N*IN_W-1:0] cur, input int thr, input bit clr);
      int nv[N], nrc[N], nspk[N];
      int nvo, nso, ncnt, pop, s;
      ncnt = clr ? 0 : (mso != 0 ? ((mcnt < 255) ? mcnt + 1 : 255) : mcnt);
      pop = 0;
      for (int i = 0; i < N; i++) pop += mspk[i];
      nvo = mvo; nso = 0;
      if (mstd != 0) begin
         s = sat(mvo - mvo / (1 << LS) + OWT * pop);
         if (s >= OTH) begin nvo = 0; nso = 1; end
         else nvo = s;
      end
      for (int i = 0; i < N; i++) begin
         nv[i] = mv[i]; nrc[i] = mrc[i]; nspk[i] = 0;
         if (st) begin
            if (REF_EN && mrc[i] > 0) begin
               nrc[i] = mrc[i] - 1; nv[i] = 0;
            end else begin
               s = sat(mv[i] - mv[i] / (1 << LS) + int'(cur[i*IN_W +: IN_W]));
               if (s >= thr) begin nv[i] = 0; nspk[i] = 1; nrc[i] = RS; end
               else nv[i] = s;
            end
         end
      end
      for (int i = 0; i < N; i++) begin mv[i] = nv[i]; mrc[i] = nrc[i]; mspk[i] = nspk[i]; end
      mvo = nvo; mso = nso; mcnt = ncnt; mstd = st;
   endtask

   task automatic drive(input bit st, input logic [N*IN_W-1:0] cur, input logic [W-1:0] thr,
                        input bit clr, input logic [2:0] sel);
      exp_t e;
      @(negedge clk); #1;
      step = st; current = cur; threshold = thr; count_clr = clr; mon_sel = sel;
      model_edge(st, cur, int'(thr), clr);
      for (int i = 0; i < N; i++) e.spk[i] = (mspk[i] != 0);
      e.so   = (mso != 0);
      e.cnt  = 8'(mcnt);
      e.vmon = (int'(sel) < N) ? W'(mv[sel]) : (int'(sel) == N) ? W'(mvo) : '0;
      q.push_back(e);
   endtask

   // Async reset with step toggling; outputs must clear at once and stay clear.
   task automatic do_reset(input int cycles);
      @(negedge clk); #1;
      rst_n = 1'b0; q.delete(); model_reset();
      #1;
      check("rst_spike", int'(spike), 0);
      check("rst_spike_out", int'(spike_out), 0);
      check("rst_count", int'(spike_count), 0);
      for (int c = 0; c < cycles; c++) begin
         @(negedge clk); #1;
         step = ~step; mon_sel = 3'($urandom_range(0, 7));
         #1;
         check("rst_hold_spike", int'(spike), 0);
         check("rst_hold_vmon", int'(v_mon), 0);
      end
      @(negedge clk); #1;
      step = 1'b0; count_clr = 1'b0; rst_n = 1'b1;
   endtask

   // Monitor: one expected entry per cycle, compared away from the active edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            check("spike", int'(spike), int'(e.spk));
            check("spike_out", int'(spike_out), int'(e.so));
            check("spike_count", int'(spike_count), int'(e.cnt));
            check("v_mon", int'(v_mon), int'(e.vmon));
         end
      end
   end

   function automatic logic [N*IN_W-1:0] all_cur(input int c);
      logic [N*IN_W-1:0] r;
      for (int i = 0; i < N; i++) r[i*IN_W +: IN_W] = IN_W'(c);
      return r;
   endfunction

   initial begin
      logic [N*IN_W-1:0] c;
      model_reset();
      do_reset(4);

      // quiet layer: no current, every monitor select reads 0
      for (int k = 0; k < 20; k++) drive(1'b1, '0, 8'd100, 1'b0, 3'(k % 8));

      // single driven neuron, continuous stepping past the second spike
      do_reset(2);
      c = '0; c[IN_W-1:0] = IN_W'(20);
      for (int k = 0; k < 22; k++) drive(1'b1, c, 8'd100, 1'b0, 3'(k % 2 == 0 ? 0 : N));

      // all neurons driven: coincident spikes push the output neuron over threshold
      do_reset(2);
      for (int k = 0; k < 12; k++) drive(1'b1, all_cur(20), 8'd100, 1'b0, 3'($urandom_range(0, N)));
      for (int k = 0; k < 3; k++) drive(1'b0, all_cur(20), 8'd100, 1'b0, 3'(N));

      // saturation at the fixed point below an unreachable threshold
      do_reset(2);
      for (int k = 0; k < 60; k++) drive(1'b1, all_cur(31), 8'd255, 1'b0, 3'($urandom_range(0, 7)));

      // threshold 0: spike every step, counter saturates, clear beats a pulse
      do_reset(2);
      for (int k = 0; k < 800; k++) drive(1'b1, 20'($urandom), 8'd0, 1'b0, 3'($urandom_range(0, 7)));
      drive(1'b1, '0, 8'd0, 1'b1, 3'(N));
      for (int k = 0; k < 4; k++) drive(1'b1, '0, 8'd0, 1'b0, 3'(N));

      // random traffic with gaps, clears and occasional mid-run resets
      do_reset(2);
      for (int k = 0; k < 3000; k++) begin
         if ($urandom_range(0, 399) == 0) do_reset(1);
         drive($urandom_range(0, 3) != 0, 20'($urandom),
               ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 20)) : 8'($urandom_range(40, 255)),
               $urandom_range(0, 29) == 0, 3'($urandom_range(0, 7)));
      end

      @(negedge clk); @(negedge clk); #1;
      check("queue_drained", q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
